dcache_responder: RTL and testbench

- Responder end of the core's data-cache port: accepts one-cycle `dcache_ren`/`dcache_wen` pulses from the control unit and returns a one-cycle `dcache_ready` pulse.
- Direct-mapped, one-word-line, write-through, no-write-allocate cache.
- Sits between the core datapath and a single-outstanding req/ack backing-memory bus.
- Also provides a one-cycle invalidate and hit/miss performance counters.

---
 rtl/dcache_pkg.sv | 31 +++
 rtl/dcache_store_array.sv | 39 +++
 rtl/dcache_responder.sv | 174 +++++++++++++++++
 tb/tb_dcache_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache responder: FSM encoding, geometry
// helpers and the byte-lane merge used by stores.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOOKUP   = 2'd1,
    MEM_WAIT = 2'd2,
    RESP     = 2'd3
  } state_t;

  // Word-addressed lines: two byte-offset bits sit below the index.
  function automatic int tag_width(input int addr_w, input int index_w);
    return addr_w - 2 - index_w;
  endfunction

  function automatic int num_lines(input int index_w);
    return 1 << index_w;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  wmask);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = wmask[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dcache_store_array.sv
// Tag and data storage for the direct-mapped cache: one registered read port,
// one write port with byte enables on the data word.
module dcache_store_array
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 24
) (
  input  logic               clk,
  input  logic               rd_en,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [31:0]        rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [31:0]        wr_data,
  input  logic [3:0]         wr_mask
);

  localparam int LINES = num_lines(INDEX_W);

  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  // NOTE: the arrays and read registers carry no reset; line contents are
  // meaningless until the matching valid bit in the top is set.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_tag  <= tag_mem[rd_idx];
      rd_data <= data_mem[rd_idx];
    end
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= merge_bytes(data_mem[wr_idx], wr_data, wr_mask);
    end
  end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache that answers the
// core's one-cycle load/store pulses and talks to a req/ack backing memory.
module dcache_responder
  import dcache_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dcache_ren,
  input  logic              dcache_wen,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [DATA_W-1:0] dcache_wdata,
  input  logic [3:0]        dcache_wmask,
  output logic              dcache_ready,
  output logic [DATA_W-1:0] dcache_rdata,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int TAG_W   = tag_width(ADDR_W, INDEX_W);
  localparam int WADDR_W = ADDR_W - 2;
  localparam int LINES   = num_lines(INDEX_W);

  state_t             state;
  logic [WADDR_W-1:0] req_waddr;
  logic [DATA_W-1:0]  req_wdata;
  logic [3:0]         req_wmask;
  logic               req_is_store;
  logic [LINES-1:0]   valid;
  logic               flush_pending;

  logic [WADDR_W-1:0] in_waddr;
  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [TAG_W-1:0]   rd_tag;
  logic [DATA_W-1:0]  rd_data;
  logic               start;
  logic               hit;
  logic               unused_addr_lsbs;

  logic               arr_wr_en;
  logic [DATA_W-1:0]  arr_wr_data;
  logic [3:0]         arr_wr_mask;

  assign in_waddr         = dcache_addr[ADDR_W-1:2];
  assign unused_addr_lsbs = ^dcache_addr[1:0];
  assign req_idx          = req_waddr[INDEX_W-1:0];
  assign req_tag          = req_waddr[WADDR_W-1:INDEX_W];
  assign start            = (state == IDLE) && (dcache_ren || dcache_wen);
  assign hit              = valid[req_idx] && (rd_tag == req_tag);

  // Array write port: store hits merge in LOOKUP, load fills land on mem_ack.
  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    arr_wr_en   = 1'b0;
    arr_wr_data = mem_rdata;
    arr_wr_mask = 4'hF;
    if (reset) begin
      if (state == LOOKUP && req_is_store && hit) begin
        arr_wr_en   = 1'b1;
        arr_wr_data = req_wdata;
        arr_wr_mask = req_wmask;
      end else if (state == MEM_WAIT && mem_ack && !req_is_store) begin
        arr_wr_en = 1'b1;
      end
    end
  end

  dcache_store_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_store_array (
    .clk     (clk),
    .rd_en   (start),
    .rd_idx  (in_waddr[INDEX_W-1:0]),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (arr_wr_en),
    .wr_idx  (req_idx),
    .wr_tag  (req_tag),
    .wr_data (arr_wr_data),
    .wr_mask (arr_wr_mask)
  );

  // NOTE: all state and registered outputs update with non-blocking
  // assignments so every branch sees the pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      req_waddr     <= '0;
      req_wdata     <= '0;
      req_wmask     <= '0;
      req_is_store  <= 1'b0;
      valid         <= '0;
      flush_pending <= 1'b0;
      dcache_ready  <= 1'b0;
      dcache_rdata  <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      dcache_ready <= 1'b0;
      // A flush seen mid-transaction waits for the return to IDLE.
      if (state != IDLE && flush) flush_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (flush || flush_pending) begin
            valid         <= '0;
            flush_pending <= 1'b0;
          end
          if (start) begin
            req_waddr    <= in_waddr;
            req_wdata    <= dcache_wdata;
            req_wmask    <= dcache_wmask;
            req_is_store <= dcache_wen;
            state        <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (hit) hit_count  <= hit_count + 32'd1;
          else     miss_count <= miss_count + 32'd1;

          if (!req_is_store && hit) begin
            dcache_ready <= 1'b1;
            dcache_rdata <= rd_data;
            state        <= RESP;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= req_is_store;
            mem_addr  <= req_waddr;
            mem_wdata <= req_is_store ? req_wdata : '0;
            mem_wmask <= req_is_store ? req_wmask : 4'h0;
            state     <= MEM_WAIT;
          end
        end

        MEM_WAIT: begin
          if (mem_ack) begin
            mem_req      <= 1'b0;
            dcache_ready <= 1'b1;
            if (!req_is_store) begin
              valid[req_idx] <= 1'b1;
              dcache_rdata   <= mem_rdata;
            end
            state <= RESP;
          end
        end

        RESP: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Randomized self-checking bench for dcache_responder; the bench also plays
// the backing memory and keeps a line-level model of the cache contents.
module tb_dcache_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dcache_ren = 1'b0;
  logic        dcache_wen = 1'b0;
  logic [31:0] dcache_addr = '0;
  logic [31:0] dcache_wdata = '0;
  logic [3:0]  dcache_wmask = '0;
  logic        dcache_ready;
  logic [31:0] dcache_rdata;
  logic        flush = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  always #5 clk = ~clk;

  dcache_responder dut (
    .clk          (clk),
    .reset        (reset),
    .dcache_ren   (dcache_ren),
    .dcache_wen   (dcache_wen),
    .dcache_addr  (dcache_addr),
    .dcache_wdata (dcache_wdata),
    .dcache_wmask (dcache_wmask),
    .dcache_ready (dcache_ready),
    .dcache_rdata (dcache_rdata),
    .flush        (flush),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Reference model: what each cache line holds, what memory holds, counts.
  bit          m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_data  [64];
  logic [31:0] mem_m   [logic [29:0]];
  logic [31:0] m_hits = '0;
  logic [31:0] m_misses = '0;
  logic [31:0] m_last_rdata = '0;

  function automatic logic [31:0] mem_rd(input logic [29:0] w);
    if (mem_m.exists(w)) return mem_m[w];
    return {2'b00, w} * 32'h9E37_79B1;
  endfunction

  function automatic logic [31:0] apply_mask(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_hits = '0;
    m_misses = '0;
    m_last_rdata = '0;
  endtask

  // Issue one request at the current negedge and follow it to completion.
  task automatic access(input bit is_store, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] wm, input int ack_dly, input bit flush_at_ack);
    logic [29:0] w;
    int          idx;
    logic [23:0] tg;
    bit          hit;
    logic [31:0] exp_rd;
    w   = addr[31:2];
    idx = int'(w[5:0]);
    tg  = w[29:6];
    hit = m_valid[idx] && (m_tag[idx] == tg);

    dcache_ren   = !is_store;
    dcache_wen   = is_store;
    dcache_addr  = addr;
    dcache_wdata = wd;
    dcache_wmask = wm;
    @(negedge clk);
    dcache_ren   = 1'b0;
    dcache_wen   = 1'b0;
    dcache_addr  = $urandom;
    dcache_wdata = $urandom;
    dcache_wmask = 4'($urandom);
    check("no_ready_after_req", {31'd0, dcache_ready}, 32'd0);
    check("no_req_in_lookup", {31'd0, mem_req}, 32'd0);
    @(negedge clk);

    if (!is_store && hit) begin
      m_hits++;
      exp_rd = m_data[idx];
      m_last_rdata = exp_rd;
      check("hit_ready", {31'd0, dcache_ready}, 32'd1);
      check("hit_rdata", dcache_rdata, exp_rd);
      check("hit_no_mem_req", {31'd0, mem_req}, 32'd0);
    end else begin
      if (hit) m_hits++;
      else     m_misses++;
      for (int i = 0; i <= ack_dly; i++) begin
        check("mem_req", {31'd0, mem_req}, 32'd1);
        check("mem_we", {31'd0, mem_we}, {31'd0, is_store});
        check("mem_addr", {2'b00, mem_addr}, {2'b00, w});
        if (is_store) begin
          check("mem_wdata", mem_wdata, wd);
          check("mem_wmask", {28'd0, mem_wmask}, {28'd0, wm});
        end
        check("wait_no_ready", {31'd0, dcache_ready}, 32'd0);
        if (i == ack_dly) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_rd(w);
          flush     = flush_at_ack;
        end else begin
          mem_rdata = $urandom;
        end
        @(negedge clk);
      end
      mem_ack   = 1'b0;
      flush     = 1'b0;
      mem_rdata = $urandom;

      if (is_store) begin
        mem_m[w] = apply_mask(mem_rd(w), wd, wm);
        if (hit) m_data[idx] = apply_mask(m_data[idx], wd, wm);
      end else begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_data[idx]  = mem_rd(w);
        m_last_rdata = m_data[idx];
      end
      if (flush_at_ack) for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;

      check("ack_ready", {31'd0, dcache_ready}, 32'd1);
      check("ack_req_drop", {31'd0, mem_req}, 32'd0);
      check("ack_rdata", dcache_rdata, m_last_rdata);
    end

    @(negedge clk);
    check("ready_single_pulse", {31'd0, dcache_ready}, 32'd0);
    check("rdata_hold", dcache_rdata, m_last_rdata);
    check("hit_count", hit_count, m_hits);
    check("miss_count", miss_count, m_misses);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    model_reset();

    // Reset state
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, dcache_ready}, 32'd0);
    check("rst_rdata", dcache_rdata, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {2'b00, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
    check("rst_hits", hit_count, 32'd0);
    check("rst_misses", miss_count, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed walk-through
    mem_m[30'h40] = 32'hDEAD_BEEF;
    access(1'b0, 32'h100, 32'h0, 4'h0, 0, 1'b0);
    check("first_load_data", dcache_rdata, 32'hDEAD_BEEF);
    access(1'b0, 32'h100, 32'h0, 4'h0, 0, 1'b0);
    check("reload_hits", hit_count, 32'd1);
    access(1'b1, 32'h100, 32'h0000_00AA, 4'b0001, 1, 1'b0);
    access(1'b0, 32'h100, 32'h0, 4'h0, 0, 1'b0);
    check("merged_word", dcache_rdata, 32'hDEAD_BEAA);
    access(1'b1, 32'h200, 32'h1234_5678, 4'b1111, 2, 1'b0);
    access(1'b0, 32'h200, 32'h0, 4'h0, 0, 1'b0);
    do_flush();
    access(1'b0, 32'h100, 32'h0, 4'h0, 5, 1'b0);
    access(1'b0, 32'h104, 32'h0, 4'h0, 1, 1'b1);
    access(1'b0, 32'h104, 32'h0, 4'h0, 0, 1'b0);

    // Reset while waiting on memory, then a late ack
    dcache_ren  = 1'b1;
    dcache_addr = 32'h300;
    @(negedge clk);
    dcache_ren = 1'b0;
    @(negedge clk);
    check("pre_reset_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("reset_drops_req", {31'd0, mem_req}, 32'd0);
    reset     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    check("late_ack_no_ready", {31'd0, dcache_ready}, 32'd0);
    @(negedge clk);
    check("late_ack_no_ready2", {31'd0, dcache_ready}, 32'd0);
    check("reset_req_idle", {31'd0, mem_req}, 32'd0);
    check("reset_hits", hit_count, 32'd0);
    check("reset_misses", miss_count, 32'd0);
    model_reset();
    access(1'b0, 32'h100, 32'h0, 4'h0, 0, 1'b0);
    check("post_reset_miss", miss_count, 32'd1);

    // Random traffic over a small address pool to mix hits, misses, conflicts
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) do_flush();
      a = ({30'd0, 2'($urandom_range(0, 3))} << 8) | ({29'd0, 3'($urandom_range(0, 7))} << 2)
          | {30'd0, 2'($urandom_range(0, 3))};
      access(1'($urandom_range(0, 2) == 0), a, $urandom, 4'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
